sensor_scheduler: RTL and testbench

//  Periodic measurement controller for the pulse-echo range sensor. Issues a trigger pulse,

---
 rtl/sensor_pkg.sv | 18 +
 rtl/sensor_sync_edge.sv | 30 +++
 rtl/sensor_scheduler.sv | 132 +++++++++++++
 tb/tb_sensor_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the pulse-echo range sensor path: FSM state encoding,
// default timing constants and counter width.
package sensor_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_e;

  localparam int unsigned TRIG_CYCLES_DEF    = 1000;
  localparam int unsigned PERIOD_CYCLES_DEF  = 6000000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 3000000;
  localparam int unsigned CNT_W_DEF          = 24;

endpackage

// File: rtl/sensor_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus one history flop that
// yields single-cycle rise/fall pulses with equal latency for both edges.
module sensor_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~hist_q;
  assign fall_o  = ~sync2_q & hist_q;

endmodule

// File: rtl/sensor_scheduler.sv
// Periodic trigger / echo-width measurement controller for one pulse-echo
// range sensor; publishes each width with a valid strobe or a timeout strobe.
module sensor_scheduler
  import sensor_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sensor,
  output logic             trig,
  output logic [CNT_W-1:0] dist_cnt,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  if (TRIG_CYCLES + TIMEOUT_CYCLES >= PERIOD_CYCLES) begin : g_bad_timing
    $error("sensor_scheduler: TRIG_CYCLES + TIMEOUT_CYCLES must be below PERIOD_CYCLES");
  end
  if ((64'(PERIOD_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_width
    $error("sensor_scheduler: CNT_W too narrow for PERIOD_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] dist_q, dist_d;
  logic             trig_q, valid_q, timeout_q, busy_q;
  logic             valid_d, timeout_d;
  logic             echo_lvl, echo_rise, echo_fall;

  sensor_sync_edge u_echo_sync (
    .clk     (clk),
    .reset   (reset),
    .d_i     (sensor),
    .level_o (echo_lvl),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      per_q     <= '0;
      to_q      <= '0;
      width_q   <= '0;
      dist_q    <= '0;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      to_q      <= to_d;
      width_q   <= width_d;
      dist_q    <= dist_d;
      trig_q    <= (state_d == S_TRIG);
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // The period counter also times the trigger pulse: it restarts at TRIG entry.
  always_comb begin
    state_d   = state_q;
    per_d     = per_q + CNT_ONE;
    to_d      = to_q;
    width_d   = width_q;
    dist_d    = dist_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        per_d = '0;
        if (enable) state_d = S_TRIG;
      end
      S_TRIG: begin
        to_d = '0;
        if (per_q == TRIG_LAST) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        to_d = to_q + CNT_ONE;
        if (to_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HOLDOFF;
        end else if (echo_rise) begin
          width_d = CNT_ONE;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        to_d = to_q + CNT_ONE;
        // A fall coinciding with the timeout limit still reports the width.
        if (echo_fall) begin
          dist_d  = width_q;
          valid_d = 1'b1;
          state_d = S_HOLDOFF;
        end else if (to_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HOLDOFF;
        end else if (echo_lvl && (width_q != '1)) begin
          width_d = width_q + CNT_ONE;
        end
      end
      S_HOLDOFF: begin
        if (per_q == PERIOD_LAST) state_d = enable ? S_TRIG : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_TRIG && state_q != S_TRIG) per_d = '0;
  end

  assign trig     = trig_q;
  assign dist_cnt = dist_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler: a table of echo scenarios in periodic
// mode plus hand sequences for reset, enable drop and reset during the trigger.
module tb_sensor_scheduler;

  localparam int unsigned TRIG    = 4;
  localparam int unsigned PERIOD  = 200;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned W       = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         sensor;
  logic         trig;
  logic [W-1:0] dist_cnt;
  logic         valid;
  logic         timeout;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sensor_scheduler #(
    .TRIG_CYCLES    (TRIG),
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sensor   (sensor),
    .trig     (trig),
    .dist_cnt (dist_cnt),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    bit    pre;   // echo held high before the trigger
    bit    on;    // drive an echo pulse after trigger fall
    int    d;     // delay from trigger fall to echo rise
    int    w;     // echo high width in cycles
    bit    ev;
    bit    et;
    int    ed;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_rise(output int r, output bit ok);
    ok = 1'b0;
    r  = -1;
    for (int i = 0; i < 450; i++) begin
      if (trig === 1'b1) begin
        ok = 1'b1;
        r  = cyc;
        return;
      end
      tick();
    end
    check("trig_rise_wait", 0, 1);
  endtask

  task automatic measure_trig(input string nm, output int fall_cyc);
    int n = 0;
    while (trig === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check({nm, "_trig_width"}, n, TRIG);
    fall_cyc = cyc;
  endtask

  task automatic drive_echo(input bit on, input int d, input int w);
    if (on) begin
      repeat (d) tick();
      sensor = 1'b1;
      repeat (w) tick();
      sensor = 1'b0;
    end
  endtask

  task automatic wait_strobe(input string nm, input bit ev, input bit et,
                             input int ed, input int fall_cyc);
    for (int i = 0; i < 250; i++) begin
      if (valid === 1'b1 || timeout === 1'b1) begin
        check({nm, "_valid"}, int'(valid), int'(ev));
        check({nm, "_timeout"}, int'(timeout), int'(et));
        check({nm, "_dist"}, int'(dist_cnt), ed);
        check({nm, "_busy"}, int'(busy), 1);
        if (et) check({nm, "_timeout_delay"}, cyc - fall_cyc, TIMEOUT);
        tick();
        check({nm, "_strobe_len"}, int'(valid | timeout), 0);
        return;
      end
      tick();
    end
    check({nm, "_strobe_wait"}, 0, 1);
  endtask

  initial begin
    int  prev_rise;
    int  r;
    int  f;
    int  n;
    bit  ok;

    vecs[0] = '{"normal",      1'b0, 1'b1, 10, 37, 1'b1, 1'b0, 37};
    vecs[1] = '{"no_echo",     1'b0, 1'b0,  0,  0, 1'b0, 1'b1, 37};
    vecs[2] = '{"stuck_high",  1'b1, 1'b0,  0,  0, 1'b0, 1'b1, 37};
    vecs[3] = '{"short",       1'b0, 1'b1,  3,  1, 1'b1, 1'b0,  1};
    vecs[4] = '{"wide_now",    1'b0, 1'b1,  0, 80, 1'b1, 1'b0, 80};
    vecs[5] = '{"fall_at_lim", 1'b0, 1'b1, 20, 77, 1'b1, 1'b0, 77};
    vecs[6] = '{"fall_past",   1'b0, 1'b1, 21, 77, 1'b0, 1'b1, 77};
    vecs[7] = '{"mid_timeout", 1'b0, 1'b1, 90, 30, 1'b0, 1'b1, 77};

    reset  = 1'b0;
    enable = 1'b0;
    sensor = 1'b0;

    // Reset held with activity on the echo pin.
    for (int i = 0; i < 8; i++) begin
      tick();
      sensor = ~sensor;
      enable = (i >= 4);
      check("rst_trig", int'(trig), 0);
      check("rst_dist", int'(dist_cnt), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_timeout", int'(timeout), 0);
      check("rst_busy", int'(busy), 0);
    end
    sensor = 1'b0;
    enable = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("idle_busy", int'(busy), 0);
    enable = 1'b1;

    prev_rise = -1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre) sensor = 1'b1;
      wait_rise(r, ok);
      if (!ok) break;
      if (prev_rise >= 0) check({vecs[i].name, "_period"}, r - prev_rise, PERIOD);
      prev_rise = r;
      measure_trig(vecs[i].name, f);
      fork
        drive_echo(vecs[i].on, vecs[i].d, vecs[i].w);
        wait_strobe(vecs[i].name, vecs[i].ev, vecs[i].et, vecs[i].ed, f);
      join
      sensor = 1'b0;
    end

    // Enable dropped while the echo is being measured.
    wait_rise(r, ok);
    if (ok) begin
      check("endrop_period", r - prev_rise, PERIOD);
      measure_trig("endrop", f);
      fork
        drive_echo(1'b1, 5, 20);
        begin
          repeat (15) tick();
          enable = 1'b0;
        end
        wait_strobe("endrop", 1'b1, 1'b0, 20, f);
      join
      n = 0;
      while (busy === 1'b1 && n < 300) begin
        n++;
        tick();
      end
      check("endrop_busy", int'(busy), 0);
      n = 0;
      for (int i = 0; i < 300; i++) begin
        if (trig === 1'b1) n++;
        tick();
      end
      check("endrop_no_trig", n, 0);
    end

    // Reset asserted on the second trigger cycle.
    enable = 1'b1;
    wait_rise(r, ok);
    if (ok) begin
      tick();
      check("rstmid_trig_before", int'(trig), 1);
      reset = 1'b0;
      #1;
      check("rstmid_trig", int'(trig), 0);
      check("rstmid_busy", int'(busy), 0);
      check("rstmid_valid", int'(valid), 0);
      check("rstmid_timeout", int'(timeout), 0);
      check("rstmid_dist", int'(dist_cnt), 0);
      repeat (3) begin
        tick();
        check("rstmid_hold_trig", int'(trig | valid | timeout), 0);
      end
      reset = 1'b1;
      wait_rise(r, ok);
      if (ok) measure_trig("rstmid_after", f);
    end

    enable = 1'b0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
